sample_fifo: RTL and testbench

Synchronous valid/ready FIFO for parallel samples, inserted between deserializer_fsm and fir_filter_transposed_partially_pipelined. It absorbs back-pressure from the filter and serializer so the deserializer never stalls mid-word. It is first-word-fall-through: the head word is always presented on ov_dout while o_dout_valid is high. It also reports occupancy and almost-full status for throttling the serial source.

---
 rtl/sample_fifo_pkg.sv | 25 ++
 rtl/sample_fifo_mem.sv | 34 +++
 rtl/sample_fifo.sv | 87 ++++++++
 tb/tb_sample_fifo.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared definitions for the sample path (deserializer -> FIFO -> filter -> serializer).
// Handshake: a word transfers on every rising edge where valid and ready are both high.
package sample_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample storage: synchronous write, asynchronous read, cleared on reset.
// Isolated so it can be replaced by a vendor RAM macro.
module sample_fifo_mem
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clearing on reset keeps the read port free of X before the first write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through valid/ready FIFO between the deserializer and the FIR filter,
// with occupancy, almost-full and sticky overflow reporting.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [DATA_WIDTH-1:0]      iv_din,
  input  logic                       i_din_valid,
  output logic                       o_ready,
  output logic [DATA_WIDTH-1:0]      ov_dout,
  output logic                       o_dout_valid,
  input  logic                       i_ready,
  output logic [clog2(DEPTH):0]      ov_count,
  output logic                       o_almost_full,
  output logic                       o_overflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  fifo_state_e   state;
  logic          full, empty, push, pop;

  // Occupancy state is implied by the pointers; the MSB is the wrap bit.
  always_comb begin
    state = FIFO_PARTIAL;
    if (wr_ptr == rd_ptr) begin
      state = FIFO_EMPTY;
    end else if (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) begin
      state = FIFO_FULL;
    end
  end

  assign full         = (state == FIFO_FULL);
  assign empty        = (state == FIFO_EMPTY);
  assign o_ready      = i_en & ~full;
  assign o_dout_valid = i_en & ~empty;
  assign push         = i_din_valid & o_ready;
  assign pop          = o_dout_valid & i_ready;
  assign ov_count     = wr_ptr - rd_ptr;

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Almost-full registered from next-state count so it lines up with ov_count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      o_almost_full <= (count_nxt >= PW'(ALMOST_FULL));
      if (i_din_valid && i_en && full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  sample_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (iv_din),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ov_dout)
  );

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: a queue model tracks contents, count and flags.
module tb_sample_fifo;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          rdy;
  logic          ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];
  int            count_m = 0;
  bit            ovf_m = 1'b0;

  always #5 clk = ~clk;

  sample_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ALMOST_FULL (AF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .iv_din        (din),
    .i_din_valid   (din_valid),
    .o_ready       (ready),
    .ov_dout       (dout),
    .o_dout_valid  (dout_valid),
    .i_ready       (rdy),
    .ov_count      (count),
    .o_almost_full (almost_full),
    .o_overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs at the falling edge, then advance the model.
  task automatic cycle(input bit r, input bit e, input bit v, input logic [DW-1:0] d, input bit rd);
    bit            push_m;
    bit            pop_m;
    logic [DW-1:0] head;
    rst       = r;
    en        = e;
    din_valid = v;
    din       = d;
    rdy       = rd;
    @(negedge clk);
    check("count", 32'(count), 32'(count_m));
    check("ready", 32'(ready), 32'(e && count_m < int'(DEPTH)));
    check("dout_valid", 32'(dout_valid), 32'(e && count_m > 0));
    check("almost_full", 32'(almost_full), 32'(count_m >= int'(AF)));
    check("overflow", 32'(overflow), 32'(ovf_m));
    push_m = e && v && count_m < int'(DEPTH);
    pop_m  = e && rd && count_m > 0;
    if (e && count_m > 0) begin
      head = sb_q[0];
      check("dout", 32'(dout), 32'(head));
    end
    if (r) begin
      sb_q.delete();
      count_m = 0;
      ovf_m   = 1'b0;
    end else begin
      if (e && v && count_m == int'(DEPTH)) ovf_m = 1'b1;
      if (pop_m) void'(sb_q.pop_front());
      if (push_m) sb_q.push_back(d);
      count_m = count_m + int'(push_m) - int'(pop_m);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    rdy       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle after reset
    repeat (2) cycle(0, 1, 0, '0, 0);

    // Fill to full with the consumer stalled, then attempt a 17th write
    for (int i = 1; i <= 16; i++) cycle(0, 1, 1, DW'(i), 0);
    cycle(0, 1, 1, 24'hDEAD00, 0);
    cycle(0, 1, 0, '0, 0);

    // Drain in order, past empty
    for (int i = 0; i < 18; i++) cycle(0, 1, 0, '0, 1);

    // Steady push+pop at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, DW'(32'h100 + i), 0);
    for (int i = 0; i < 40; i++) cycle(0, 1, 1, DW'($urandom), 1);

    // Down to 3 words, then freeze with enable low while toggling handshakes
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, i[0], DW'(32'h777 + i), ~i[0]);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 1);

    // Reset at count 9 while pushing and popping
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, DW'(32'h900 + i), 0);
    cycle(1, 1, 1, 24'hBADBAD, 1);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 1, 24'hABCDEF, 0);
    repeat (3) cycle(0, 1, 0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
